table_loader: RTL

TABLE_LOADER -- requirements
Module: table_loader

---
 rtl/table_loader.sv | 87 ++++++++
 1 files changed

// File: rtl/table_loader.sv
// Streams words from a valid/ready input into a 2**aw-entry table through a registered write port.
// It keeps a running modulo-2**dw checksum and flags whether a pass completed or was aborted.
module table_loader #(
  parameter int              aw = 10,
  parameter int              dw = 8,
  parameter logic [dw-1:0]   iv = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [dw-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [aw-1:0] wr_addr,
  output logic [dw-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] checksum,
  output logic          err
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high.
  // in_ready depends only on state and abort, never on in_valid.
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [aw-1:0] count;
  logic          accept;
  logic          last;
  logic          restart;

  assign in_ready = (state == LOAD) && !abort;
  assign accept   = in_valid && in_ready;
  assign last     = accept && (count == {aw{1'b1}});
  assign restart  = (state != LOAD) && start;
  assign busy     = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = LOAD;
      LOAD: begin
        if (abort)     next_state = IDLE;
        else if (last) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write port is registered: an accepted word appears on wr_* one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= iv;
      done     <= 1'b0;
      checksum <= '0;
      err      <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr  <= count;
        wr_data  <= in_data;
        count    <= count + aw'(1);
        checksum <= checksum + in_data;
        if (last) done <= 1'b1;
      end
      if (restart) begin
        count    <= '0;
        checksum <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
      end
      if ((state == LOAD) && abort) err <= 1'b1;
    end
  end

endmodule
